// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: registered round-robin arbiter with hold-time limit and one-hot grants
module round_robin_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id
);
    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IW-1:0]   id_q, id_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [N-1:0]    cand;
    logic [IW:0]     idx;
    logic            found;
    logic [IW-1:0]   win;
    logic            keep;

    // Winner search: first candidate at or after ptr, wrapping; the current owner is never a candidate
    always_comb begin
        cand  = req & ~grant_q;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr_q} + (IW+1)'(k);
            if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
            if (!found && cand[idx[IW-1:0]]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
    end

    // Next state: owner keeps the grant unless it dropped or timed out with someone waiting
    always_comb begin
        keep    = state_q == BUSY && req[id_q] && !(hold_q == HW'(MAX_HOLD) && found);
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        if (keep) begin
            hold_d = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + HW'(1);
        end else if (found) begin
            state_d = BUSY;
            grant_d = N'(1) << win;
            id_d    = win;
            hold_d  = HW'(1);
            ptr_d   = (win == IW'(N - 1)) ? '0 : win + IW'(1);
        end else begin
            state_d = IDLE;
            grant_d = '0;
            id_d    = '0;
            hold_d  = '0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_id    = id_q;
endmodule

// File: tb/tb_round_robin_arbiter.sv
// tb_round_robin_arbiter: directed and randomized checks of round_robin_arbiter against a reference model
module tb_round_robin_arbiter;
    localparam int N  = 4;
    localparam int MH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_id;

    int pass_cnt = 0;
    int total = 0;
    int owner = -1;
    int held = 0;
    int nxt = 0;

    round_robin_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [N-1:0] r, input int start, input int excl);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic take(input int w);
        owner = w;
        held  = 1;
        nxt   = (w + 1) % N;
    endtask

    task automatic model(input logic [N-1:0] r, input logic rn);
        int w;
        if (!rn) begin
            owner = -1; held = 0; nxt = 0;
        end else if (owner < 0) begin
            w = pick(r, nxt, -1);
            if (w >= 0) take(w);
        end else if (!r[owner]) begin
            w = pick(r, nxt, owner);
            if (w >= 0) take(w);
            else begin owner = -1; held = 0; end
        end else begin
            w = pick(r, nxt, owner);
            if (held >= MH && w >= 0) take(w);
            else held = (held < MH) ? held + 1 : MH;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input logic [N-1:0] r, input logic rn);
        req   = r;
        rst_n = rn;
        @(posedge clk);
        #1;
        model(r, rn);
        chk("grant", 32'(grant), owner < 0 ? 32'd0 : 32'd1 << owner);
        chk("valid", 32'(grant_valid), owner < 0 ? 32'd0 : 32'd1);
        chk("id", 32'(grant_id), owner < 0 ? 32'd0 : 32'(owner));
    endtask

    initial begin
        // Reset with all requesting
        step(4'b1111, 1'b0);
        chk("rst_grant0", 32'(grant), 32'h0);
        step(4'b1111, 1'b0);
        chk("rst_grant1", 32'(grant), 32'h0);
        step(4'b1111, 1'b1);
        chk("post_rst", 32'(grant), 32'h1);
        // Fair rotation with wrap
        for (int c = 1; c <= 20; c++) begin
            step(4'b1111, 1'b1);
            chk("rotate", 32'(grant), 32'd1 << ((c / MH) % N));
        end
        // Drop handoff from 0010
        step(4'b1101, 1'b1);
        chk("drop_handoff", 32'(grant), 32'h4);
        // Sole requester then late arrival at index 0
        for (int c = 0; c < 10; c++) begin
            step(4'b0100, 1'b1);
            chk("sole", 32'(grant), 32'h4);
        end
        step(4'b0101, 1'b1);
        chk("sole_timeout", 32'(grant), 32'h1);
        // Single-cycle pulse from IDLE
        step(4'b0000, 1'b1);
        chk("to_idle", 32'(grant), 32'h0);
        step(4'b1000, 1'b1);
        chk("pulse_on", 32'(grant), 32'h8);
        step(4'b0000, 1'b1);
        chk("pulse_off", 32'(grant), 32'h0);
        // Reset mid-grant
        step(4'b0100, 1'b1);
        chk("mid_grant", 32'(grant), 32'h4);
        step(4'b1111, 1'b0);
        chk("mid_rst", 32'(grant), 32'h0);
        step(4'b1111, 1'b1);
        chk("mid_rst_after", 32'(grant), 32'h1);
        // Randomized traffic with occasional reset
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] r;
            r = (c % 40 < 20) ? N'($urandom) | N'($urandom) : N'($urandom) & N'($urandom);
            step(r, ($urandom_range(0, 59) != 0));
            chk("onehot", 32'($countones(grant) <= 1), 32'd1);
        end
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/round_robin_arbiter.md
# round_robin_arbiter

Registered round-robin arbiter that shares one resource among N requesters. It replaces static highest-index-wins priority with a rotating pointer, so no requester starves. A grant is held while the owner keeps requesting, and is forcibly rotated after MAX_HOLD cycles if another requester is waiting. It sits in front of any shared datapath or bus port that needs fair, glitch-free, one-hot grants.

## Interface
- N, default 4: number of requesters (2..16).
- MAX_HOLD, default 8: maximum consecutive grant cycles while another requester is pending (1..255).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  N  request vector; bit i high = requester i wants the resource.
- grant  output  N  registered one-hot grant, or all zero.
- grant_valid  output  1  high when any grant bit is set.
- grant_id  output  clog2(N)  index of the granted requester; 0 when grant_valid is low.

## Operation
- Internal state:
  - ptr (clog2(N)): search start index.
  - hold_cnt (clog2(MAX_HOLD+1)): cycles the current owner has held the grant.
  - FSM: IDLE (no grant) and BUSY (grant held).
- Winner search: scan req from index ptr upward, wrapping modulo N. The first set bit wins.
- IDLE:
  - If req is zero, stay in IDLE.
  - Otherwise, on the next edge: grant = winner, grant_id = winner index, hold_cnt = 1, ptr = (winner+1) mod N, go to BUSY.
- BUSY, each cycle, evaluated in this order:
  - Drop release: req[grant_id] == 0.
    - Pick a winner from the remaining requests and move the grant directly to it. There is no idle cycle between owners.
    - If no other request is pending, go to IDLE with grant = 0. ptr is unchanged.
  - Timeout release: hold_cnt == MAX_HOLD and (req & ~grant) != 0.
    - The owner is excluded from the search. The winner is chosen among the other requesters.
    - The grant moves to the winner; hold_cnt = 1; ptr = winner+1 mod N.
  - Otherwise the owner keeps the grant. hold_cnt increments and saturates at MAX_HOLD.
    - A sole requester therefore keeps the grant indefinitely.
- Bus-mastering rule: grant changes only on a clock edge, and is always one-hot or zero.
- Width and arithmetic:
  - ptr wraps N-1 -> 0.
  - For non-power-of-two N, indices >= N are never produced.
  - hold_cnt never exceeds MAX_HOLD.

## Timing
- Reset: after an edge with rst_n low, grant = 0, grant_valid = 0, grant_id = 0, ptr = 0, hold_cnt = 0, FSM = IDLE.
  - Reset overrides every request, including in the middle of a grant.
- Latency: a request sampled at edge t is granted at edge t+1 at the earliest.
- Release latency: the owner dropping req at edge t removes or moves its grant at edge t+1.
  - The owner is charged for one cycle of grant after its request drops. Requesters must tolerate this.
- Simultaneous events:
  - Owner drop and timeout in the same cycle: treat as a drop release.
  - New requests that arrive in the same cycle as a release are eligible for the search.
- grant, grant_valid and grant_id are driven from flops only. There is no combinational path from req to any output.

## Test plan
- Reset: hold rst_n low for 2 cycles with req = 1111 -> grant = 0000, valid = 0 throughout. At the first edge after release -> grant = 0001, grant_id = 0.
- Fair rotation, N = 4, MAX_HOLD = 4: req = 1111 held constant -> grant 0001 for 4 cycles, then 0010 for 4, 0100 for 4, 1000 for 4, then 0001 again (wrap).
- Drop handoff: owner holds 0010 with req = 1111; req changes to 1101 -> next edge grant = 0100, with no zero cycle between owners.
- Sole requester: req = 0100 for 10 cycles -> grant stays 0100 and hold_cnt saturates at 4. Then req = 0101 -> next edge grant = 0001 (ptr = 3, search 3 -> 0).
- Single-cycle pulse: from IDLE, req = 0000 -> 1000 -> 0000 on consecutive cycles -> grant = 1000 for exactly one cycle, one edge after the pulse, then 0000 and IDLE.
- Reset mid-grant: grant = 0100, pull rst_n low for 1 cycle with req = 1111 -> grant = 0000. At the first edge after release -> grant = 0001 (ptr reset to 0).
